// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mult/div op encoding, decoder funct codes and
// the multiply/divide unit state encoding.
package mips_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } t_md_op;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } t_md_state;

    // R-type funct field values the core decoder maps onto t_md_op.
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic md_is_signed(input t_md_op op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic md_is_div(input t_md_op op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mips_md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Pure combinational; the caller holds the accumulators.
module mips_md_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // Multiply keeps the multiplier in acc_lo and retires its LSB each step;
    // divide keeps the dividend in acc_lo and shifts quotient bits in.
    always_comb begin
        w_sum     = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : '0);
        w_shifted = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_operand};
        if (i_is_div) begin
            o_acc_hi = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
            o_acc_hi = w_sum[WIDTH:1];
            o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Operates on magnitudes and
// applies the sign correction in a single FIX cycle at the end.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  t_md_op           op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    t_md_state        r_state;
    t_md_state        w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_done;

    logic             w_accept;
    logic             w_is_md;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [2*WIDTH-1:0] w_prod;

    mips_md_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div  (r_is_div),
        .i_acc_hi  (r_acc_hi),
        .i_acc_lo  (r_acc_lo),
        .i_operand (r_operand),
        .o_acc_hi  (w_step_hi),
        .o_acc_lo  (w_step_lo)
    );

    // Requests are only honoured in IDLE; anything arriving while busy is dropped.
    always_comb begin
        w_accept   = start && (r_state == IDLE);
        w_is_md    = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
        w_is_div   = md_is_div(op);
        w_sign_a   = md_is_signed(op) && op_a[WIDTH-1];
        w_sign_b   = md_is_signed(op) && op_b[WIDTH-1];
        w_abs_a    = w_sign_a ? -op_a : op_a;
        w_abs_b    = w_sign_b ? -op_b : op_b;
        w_div_zero = w_is_div && (op_b == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_md) w_next_state = w_div_zero ? FIX : CALC;
            CALC:    if (r_count == '0) w_next_state = FIX;
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != IDLE);
        w_prod = {r_acc_hi, r_acc_lo};
        if (r_neg_res) w_prod = -w_prod;
        w_quot = r_neg_res ? -r_acc_lo : r_acc_lo;
        w_rem  = r_neg_rem ? -r_acc_hi : r_acc_hi;
    end

    // Divide-by-zero preloads the accumulators with the architectural result
    // and clears the sign flags so FIX passes it through untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (op == MTHI) begin
                            r_hi <= op_a;
                        end else if (op == MTLO) begin
                            r_lo <= op_a;
                        end else if (w_is_md) begin
                            r_is_div <= w_is_div;
                            r_count  <= CW'(ITER - 1);
                            r_acc_hi <= '0;
                            if (w_div_zero) begin
                                r_acc_hi  <= op_a;
                                r_acc_lo  <= '1;
                                r_operand <= op_b;
                                r_neg_res <= 1'b0;
                                r_neg_rem <= 1'b0;
                            end else begin
                                r_acc_lo  <= w_is_div ? w_abs_a : w_abs_b;
                                r_operand <= w_is_div ? w_abs_b : w_abs_a;
                                r_neg_res <= w_sign_a ^ w_sign_b;
                                r_neg_rem <= w_sign_a;
                            end
                        end
                    end
                end
                CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_count  <= r_count - 1'b1;
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_lo <= w_quot;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit with hand-computed
// HI/LO results, latencies and handshake behaviour.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    t_md_op      op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectorCount;
    int miscompareCount;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    mips_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .op_a  (opA),
        .op_b  (opB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            miscompareCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input t_md_op opIn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = opIn;
        opA   = a;
        opB   = b;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runMulDiv(input string tag, input t_md_op opIn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expHi,
                             input logic [31:0] expLo, input int expLatency);
        int cycles;
        applyStimulus(opIn, a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, " hold hi"}, hi, modelHi);
        checkOutput({tag, " hold lo"}, lo, modelLo);
        waitDone(cycles);
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({tag, " hi"}, hi, expHi);
        checkOutput({tag, " lo"}, lo, expLo);
        checkOutput({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse"}, {31'd0, done}, 32'd0);
        modelHi = expHi;
        modelLo = expLo;
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        modelHi = 32'h0;
        modelLo = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        op    = MULTU;
        opA   = 32'h0;
        opB   = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        reset = 1'b0;

        runMulDiv("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        runMulDiv("mult -3x7", MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        runMulDiv("multu -3x7", MULTU, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB, 34);
        runMulDiv("div -7/2", DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        runMulDiv("divu 7/2", DIVU, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 34);
        runMulDiv("div ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);
        runMulDiv("divu by0", DIVU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 2);

        // Back-to-back MTHI then MTLO, each visible right after its own edge.
        applyStimulus(MTHI, 32'hAAAA_5555, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mthi hi", hi, 32'hAAAA_5555);
        checkOutput("mthi lo kept", lo, modelLo);
        checkOutput("mthi busy", {31'd0, busy}, 32'd0);
        checkOutput("mthi done", {31'd0, done}, 32'd0);
        op  = MTLO;
        opA = 32'h0F0F_0F0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mtlo lo", lo, 32'h0F0F_0F0F);
        checkOutput("mtlo hi kept", hi, 32'hAAAA_5555);
        checkOutput("mtlo done", {31'd0, done}, 32'd0);
        modelHi = 32'hAAAA_5555;
        modelLo = 32'h0F0F_0F0F;

        // MTHI issued mid-operation must be dropped.
        applyStimulus(MULTU, 32'h0000_0002, 32'h0000_0003);
        @(posedge clk);
        #1;
        op    = MTHI;
        opA   = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mthi busy ignored", hi, 32'hAAAA_5555);
        begin
            int cycles;
            waitDone(cycles);
            checkOutput("2x3 latency", 32'(cycles), 32'd33);
        end
        checkOutput("2x3 hi", hi, 32'h0);
        checkOutput("2x3 lo", lo, 32'h6);
        @(posedge clk);
        #1;
        checkOutput("2x3 late mthi", hi, 32'h0);

        // Reset in the tenth CALC cycle of a MULT.
        applyStimulus(MULT, 32'h0000_1234, 32'hFFFF_FFFB);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid reset done", {31'd0, done}, 32'd0);
        checkOutput("mid reset hi", hi, 32'h0);
        checkOutput("mid reset lo", lo, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) checkOutput("no done after reset", {31'd0, done}, 32'd0);
        end
        checkOutput("post reset busy", {31'd0, busy}, 32'd0);
        modelHi = 32'h0;
        modelLo = 32'h0;

        runMulDiv("multu 3x5", MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
